// File: rtl/seq_shifter.sv
// Multi-cycle barrel-free shifter: rotates or logically shifts a 16-bit operand
// by up to 15 places, stepping two bits per clock, and pulses done with the result.
module seq_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [1:0]  op,
  input  logic [3:0]  cnt,
  output logic [15:0] out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [15:0] work;
  logic [15:0] stepped;
  logic [3:0]  rem;
  logic [3:0]  rem_nx;
  logic [1:0]  op_q;

  // One step moves two places, or one when only a single place remains.
  function automatic logic [15:0] step(input logic [15:0] v,
                                       input logic [1:0]  o,
                                       input logic        two);
    logic [15:0] r;
    r = v;
    case (o)
      2'b00:   r = two ? {v[13:0], v[15:14]} : {v[14:0], v[15]};
      2'b01:   r = two ? {v[13:0], 2'b00}    : {v[14:0], 1'b0};
      2'b10:   r = two ? {v[1:0], v[15:2]}   : {v[0], v[15:1]};
      default: r = two ? {2'b00, v[15:2]}    : {1'b0, v[15:1]};
    endcase
    return r;
  endfunction

  always_comb begin
    stepped = step(work, op_q, rem >= 4'd2);
    rem_nx  = (rem >= 4'd2) ? rem - 4'd2 : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (cnt == 4'd0) ? DONE : SHIFT;
      SHIFT:   if (rem_nx == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // out only moves on DONE entry, so it holds steady through every SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      work <= 16'd0;
      rem  <= 4'd0;
      op_q <= 2'd0;
      out  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work <= in;
            op_q <= op;
            rem  <= cnt;
            if (cnt == 4'd0) out <= in;
          end
        end
        SHIFT: begin
          work <= stepped;
          rem  <= rem_nx;
          if (rem_nx == 4'd0) out <= stepped;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: expected results are queued at issue time and
// matched by an independent monitor against every done pulse.
module tb_seq_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] din;
  logic [1:0]  dop;
  logic [3:0]  dcnt;
  logic [15:0] dout;
  logic        busy;
  logic        done;

  int          checks;
  int          miscompares;
  logic [15:0] expq[$];

  seq_shifter dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .in   (din),
    .op   (dop),
    .cnt  (dcnt),
    .out  (dout),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [15:0] exp;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp = expq.pop_front();
          checkOutput("result", {16'd0, dout}, {16'd0, exp});
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [1:0] o,
                               input logic [3:0] c, input logic [15:0] expout,
                               input bit midstart, input bit donestart);
    int edges;
    int busycycles;
    int k;
    bit seen;
    k = (int'(c) + 1) / 2;
    expq.push_back(expout);
    @(negedge clk);
    din = a; dop = o; dcnt = c; start = 1'b1;
    @(posedge clk);
    edges = 1;
    busycycles = 0;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b0; din = ~a; dop = ~o; dcnt = ~c;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      if (busy === 1'b1) busycycles++;
      if (done === 1'b1) begin
        seen = 1'b1;
        if (donestart) begin
          start = 1'b1; din = 16'h5A5A; dop = 2'b00; dcnt = 4'd3;
        end
      end else begin
        start = midstart && (i == 1);
        if (start) begin
          din = 16'h0F0F; dop = 2'b01; dcnt = 4'd1;
        end
        @(posedge clk);
        edges++;
      end
    end
    if (!seen) begin
      checkOutput("timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("latency", edges, k + 1);
      checkOutput("busy_cycles", busycycles, k + 1);
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b0; din = 16'd0; dop = 2'd0; dcnt = 4'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out", {16'd0, dout}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(16'h8001, 2'b00, 4'd1,  16'h0003, 1'b0, 1'b0);
    applyStimulus(16'h1234, 2'b00, 4'd4,  16'h2341, 1'b0, 1'b0);
    applyStimulus(16'h00F0, 2'b10, 4'd5,  16'h8007, 1'b0, 1'b1);
    applyStimulus(16'h8001, 2'b11, 4'd15, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h8001, 2'b01, 4'd15, 16'h8000, 1'b0, 1'b0);
    applyStimulus(16'hABCD, 2'b01, 4'd0,  16'hABCD, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 2'b11, 4'd8,  16'h00FF, 1'b1, 1'b0);
    applyStimulus(16'h8001, 2'b10, 4'd1,  16'hC000, 1'b0, 1'b0);
    applyStimulus(16'h1234, 2'b01, 4'd3,  16'h91A0, 1'b0, 1'b0);
    checkOutput("out_held_in_idle", {16'd0, dout}, 32'h91A0);

    // Abort mid-operation: reset lands on the second SHIFT edge.
    @(negedge clk);
    din = 16'h1234; dop = 2'b00; dcnt = 4'd8; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_out", {16'd0, dout}, 32'd0);
    repeat (8) @(negedge clk);
    checkOutput("abort_out_held", {16'd0, dout}, 32'd0);

    applyStimulus(16'h00F0, 2'b10, 4'd5, 16'h8007, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("pending_results", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
    $finish;
  end

endmodule
